pll_reset_sequencer: RTL and testbench

//  Reset/lock controller wrapped around the system PLL. Holds the PLL in reset after power-up or a soft

---
 rtl/pll_reset_sequencer.sv | 112 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset/lock sequencer around the system PLL: pulses the PLL reset, waits for a stable
// synchronised lock, then releases the core reset after a settle delay.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_DELAY       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] lock_lost_cnt,
  output logic [2:0] state_dbg
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CD = (LOCK_TIMEOUT_CYCLES > RELEASE_DELAY) ? LOCK_TIMEOUT_CYCLES : RELEASE_DELAY;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             lock_lost;
  logic             locked_p0;
  logic             locked_s;

  // Stage p0/s: two-flop synchroniser for the asynchronous lock pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_p0 <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      locked_p0 <= pll_locked;
      locked_s  <= locked_p0;
    end
  end

  always_comb begin
    next_state = state;
    lock_lost  = 1'b0;
    case (state)
      PLL_RST:   if (cnt == PLL_RST_LAST) next_state = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s)                  next_state = STABLE;
        else if (cnt == TIMEOUT_LAST)  next_state = PLL_RST;
      end
      STABLE: begin
        if (!locked_s)                 next_state = WAIT_LOCK;
        else if (cnt == STABLE_LAST)   next_state = RELEASE;
      end
      RELEASE: begin
        if (!locked_s)                 next_state = WAIT_LOCK;
        else if (cnt == RELEASE_LAST)  next_state = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          next_state = PLL_RST;
          lock_lost  = 1'b1;
        end
      end
      default:                         next_state = PLL_RST;
    endcase
    // A soft request overrides everything; a coincident RUN lock loss is still counted above.
    if (soft_rst_req) next_state = PLL_RST;
    cnt_clr = (next_state != state) || soft_rst_req;
  end

  // Stage p1: state, counter and outputs all register off next_state on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PLL_RST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      lock_lost_cnt <= 8'd0;
    end else begin
      state     <= next_state;
      pll_rst   <= (next_state == PLL_RST);
      sys_rst_n <= (next_state == RUN);
      ready     <= (next_state == RUN);
      if (cnt_clr)
        cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})
        cnt <= cnt + CNT_W'(1);
      if (lock_lost && (lock_lost_cnt != 8'hFF))
        lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (params 4/8/32/4): expected output values are
// queued at each step and compared against the DUT once the step's edges have elapsed.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       soft_rst_req;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sbq[$];

  localparam int S_PLL_RST = 0, S_SYS = 1, S_READY = 2, S_LOST = 3, S_STATE = 4;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .RELEASE_DELAY(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .soft_rst_req(soft_rst_req),
    .pll_locked(pll_locked),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .lock_lost_cnt(lock_lost_cnt),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] observe(int sig);
    case (sig)
      S_PLL_RST: return {7'd0, pll_rst};
      S_SYS:     return {7'd0, sys_rst_n};
      S_READY:   return {7'd0, ready};
      S_LOST:    return lock_lost_cnt;
      default:   return {5'd0, state_dbg};
    endcase
  endfunction

  task automatic expect_sig(input string tag, input int sig, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic check_all();
    exp_t       e;
    logic [7:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sig);
      total++;
      assert (obs === e.exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // PLL reset and system release must never overlap
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!(sys_rst_n && pll_rst))
      else begin
        bad++;
        $error("FAIL overlap: sys_rst_n=%0b pll_rst=%0b expected not both 1", sys_rst_n, pll_rst);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    soft_rst_req = 1'b0;
    pll_locked   = 1'b0;
    adv(2);
    expect_sig("rst_pll_rst", S_PLL_RST, 8'd1);
    expect_sig("rst_sys", S_SYS, 8'd0);
    expect_sig("rst_ready", S_READY, 8'd0);
    expect_sig("rst_lost", S_LOST, 8'd0);
    expect_sig("rst_state", S_STATE, 8'd0);
    check_all();

    // Constant lock: release at edge 0, pll_rst falls at 4, RUN at 17
    pll_locked = 1'b1;
    rst_n      = 1'b1;
    adv(3);
    expect_sig("t1_e3_pll_rst", S_PLL_RST, 8'd1);
    expect_sig("t1_e3_state", S_STATE, 8'd0);
    check_all();
    adv(1);
    expect_sig("t1_e4_pll_rst", S_PLL_RST, 8'd0);
    expect_sig("t1_e4_state", S_STATE, 8'd1);
    check_all();
    adv(1);
    expect_sig("t1_e5_state", S_STATE, 8'd2);
    check_all();
    adv(8);
    expect_sig("t1_e13_state", S_STATE, 8'd3);
    check_all();
    adv(3);
    expect_sig("t1_e16_state", S_STATE, 8'd3);
    expect_sig("t1_e16_sys", S_SYS, 8'd0);
    expect_sig("t1_e16_ready", S_READY, 8'd0);
    check_all();
    adv(1);
    expect_sig("t1_e17_state", S_STATE, 8'd4);
    expect_sig("t1_e17_sys", S_SYS, 8'd1);
    expect_sig("t1_e17_ready", S_READY, 8'd1);
    expect_sig("t1_e17_pll_rst", S_PLL_RST, 8'd0);
    expect_sig("t1_e17_lost", S_LOST, 8'd0);
    check_all();

    // One-cycle lock glitch in RUN: sys_rst_n drops on the third edge
    pll_locked = 1'b0;
    adv(1);
    pll_locked = 1'b1;
    adv(1);
    expect_sig("t3_e2_sys", S_SYS, 8'd1);
    expect_sig("t3_e2_state", S_STATE, 8'd4);
    check_all();
    adv(1);
    expect_sig("t3_e3_sys", S_SYS, 8'd0);
    expect_sig("t3_e3_pll_rst", S_PLL_RST, 8'd1);
    expect_sig("t3_e3_state", S_STATE, 8'd0);
    expect_sig("t3_e3_lost", S_LOST, 8'd1);
    check_all();
    adv(16);
    expect_sig("t3_rerun_pre_sys", S_SYS, 8'd0);
    expect_sig("t3_rerun_pre_state", S_STATE, 8'd3);
    check_all();
    adv(1);
    expect_sig("t3_rerun_sys", S_SYS, 8'd1);
    expect_sig("t3_rerun_ready", S_READY, 8'd1);
    check_all();

    // Soft restart, then a lock drop after 5 cycles in STABLE
    soft_rst_req = 1'b1;
    adv(1);
    soft_rst_req = 1'b0;
    expect_sig("t4_soft_state", S_STATE, 8'd0);
    expect_sig("t4_soft_pll_rst", S_PLL_RST, 8'd1);
    expect_sig("t4_soft_sys", S_SYS, 8'd0);
    expect_sig("t4_soft_lost", S_LOST, 8'd1);
    check_all();
    adv(5);
    expect_sig("t4_stable_entry", S_STATE, 8'd2);
    check_all();
    adv(3);
    pll_locked = 1'b0;
    adv(1);
    pll_locked = 1'b1;
    adv(2);
    expect_sig("t4_back_wait", S_STATE, 8'd1);
    check_all();
    adv(1);
    expect_sig("t4_restable", S_STATE, 8'd2);
    check_all();
    adv(7);
    expect_sig("t4_still_stable", S_STATE, 8'd2);
    check_all();
    adv(1);
    expect_sig("t4_release", S_STATE, 8'd3);
    check_all();
    adv(3);
    expect_sig("t4_pre_run_sys", S_SYS, 8'd0);
    check_all();
    adv(1);
    expect_sig("t4_run_sys", S_SYS, 8'd1);
    expect_sig("t4_run_state", S_STATE, 8'd4);
    check_all();

    // Soft request coincident with a lock loss in RUN counts exactly once
    pll_locked = 1'b0;
    adv(1);
    pll_locked = 1'b1;
    adv(1);
    expect_sig("t5_pre_state", S_STATE, 8'd4);
    expect_sig("t5_pre_sys", S_SYS, 8'd1);
    check_all();
    soft_rst_req = 1'b1;
    adv(1);
    soft_rst_req = 1'b0;
    expect_sig("t5_state", S_STATE, 8'd0);
    expect_sig("t5_lost", S_LOST, 8'd2);
    expect_sig("t5_pll_rst", S_PLL_RST, 8'd1);
    expect_sig("t5_sys", S_SYS, 8'd0);
    check_all();

    for (int i = 0; i < 300; i++) begin
      adv(17);
      expect_sig("t5_loop_run", S_STATE, 8'd4);
      check_all();
      pll_locked = 1'b0;
      adv(1);
      pll_locked = 1'b1;
      adv(2);
      if (i == 251) begin
        expect_sig("t5_lost_254", S_LOST, 8'd254);
        check_all();
      end
    end
    expect_sig("t5_lost_sat", S_LOST, 8'd255);
    expect_sig("t5_loop_end_state", S_STATE, 8'd0);
    check_all();

    // Asynchronous reset in the middle of RELEASE
    adv(14);
    expect_sig("t6_release_state", S_STATE, 8'd3);
    expect_sig("t6_release_pll_rst", S_PLL_RST, 8'd0);
    check_all();
    #2;
    rst_n = 1'b0;
    #1;
    expect_sig("t6_async_pll_rst", S_PLL_RST, 8'd1);
    expect_sig("t6_async_sys", S_SYS, 8'd0);
    expect_sig("t6_async_ready", S_READY, 8'd0);
    expect_sig("t6_async_state", S_STATE, 8'd0);
    expect_sig("t6_async_lost", S_LOST, 8'd0);
    check_all();

    // Lock never arrives: 4 high / 32 low retry cycle
    pll_locked = 1'b0;
    adv(2);
    rst_n = 1'b1;
    adv(3);
    expect_sig("t2_e3_pll_rst", S_PLL_RST, 8'd1);
    check_all();
    adv(1);
    expect_sig("t2_e4_pll_rst", S_PLL_RST, 8'd0);
    expect_sig("t2_e4_state", S_STATE, 8'd1);
    check_all();
    adv(31);
    expect_sig("t2_e35_pll_rst", S_PLL_RST, 8'd0);
    expect_sig("t2_e35_state", S_STATE, 8'd1);
    expect_sig("t2_e35_sys", S_SYS, 8'd0);
    check_all();
    adv(1);
    expect_sig("t2_e36_pll_rst", S_PLL_RST, 8'd1);
    expect_sig("t2_e36_state", S_STATE, 8'd0);
    check_all();
    adv(3);
    expect_sig("t2_e39_pll_rst", S_PLL_RST, 8'd1);
    check_all();
    adv(1);
    expect_sig("t2_e40_pll_rst", S_PLL_RST, 8'd0);
    check_all();
    adv(31);
    expect_sig("t2_e71_pll_rst", S_PLL_RST, 8'd0);
    check_all();
    adv(1);
    expect_sig("t2_e72_pll_rst", S_PLL_RST, 8'd1);
    expect_sig("t2_e72_sys", S_SYS, 8'd0);
    check_all();

    // Held soft request parks in PLL_RST with the counter at zero
    pll_locked   = 1'b1;
    soft_rst_req = 1'b1;
    adv(40);
    expect_sig("hold_state", S_STATE, 8'd0);
    expect_sig("hold_pll_rst", S_PLL_RST, 8'd1);
    expect_sig("hold_sys", S_SYS, 8'd0);
    check_all();
    soft_rst_req = 1'b0;
    adv(3);
    expect_sig("hold_rel_e3_pll_rst", S_PLL_RST, 8'd1);
    check_all();
    adv(1);
    expect_sig("hold_rel_e4_pll_rst", S_PLL_RST, 8'd0);
    expect_sig("hold_rel_e4_state", S_STATE, 8'd1);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
